// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_IN requesters.
// Grants are held for a whole burst; a burst only starts when the FIFO can absorb MAX_BURST beats.
module fifo_rr_arbiter #(
  parameter int unsigned NUM_IN    = 4,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned FIFO_NUM  = 4,
  parameter int unsigned MAX_BURST = 2,
  localparam int unsigned IdxW  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1,
  localparam int unsigned FreeW = $clog2(FIFO_NUM) + 1,
  localparam int unsigned CntW  = $clog2(MAX_BURST) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN-1:0]       IN_valid,
  input  logic [NUM_IN*WIDTH-1:0] IN_data,
  input  logic [NUM_IN-1:0]       IN_last,
  output logic [NUM_IN-1:0]       OUT_ready,
  input  logic [FreeW-1:0]        IN_free,
  output logic                    OUT_valid,
  output logic [WIDTH-1:0]        OUT_data,
  input  logic                    IN_ready,
  output logic [IdxW-1:0]         OUT_grantIdx,
  output logic                    OUT_locked,
  output logic                    OUT_burstErr
);

  typedef enum logic {StIdle, StBurst} state_e;

  localparam logic [FreeW-1:0] MaxBurstFree = FreeW'(MAX_BURST);
  localparam logic [CntW-1:0]  MaxBurstCnt  = CntW'(MAX_BURST);
  localparam logic [IdxW-1:0]  LastIdx      = IdxW'(NUM_IN - 1);

  state_e          r_state;
  logic [IdxW-1:0] r_owner;
  logic [IdxW-1:0] r_rr_ptr;
  logic [CntW-1:0] r_beat_cnt;
  logic            r_burst_err;

  state_e          w_state_d;
  logic [IdxW-1:0] w_owner_d;
  logic [IdxW-1:0] w_rr_ptr_d;
  logic [CntW-1:0] w_beat_cnt_d;
  logic            w_burst_err_d;

  logic [IdxW-1:0] w_sel;
  logic [IdxW-1:0] w_cand;
  logic            w_found;
  logic            w_locked;
  logic            w_gate;
  logic            w_fire;
  logic            w_last;
  logic            w_overrun;
  logic [IdxW-1:0] w_next_ptr;

  assign w_locked = (r_state == StBurst);

  // First valid requester at or after rrPtr; the lock pins selection to the owner.
  always_comb begin
    w_sel   = r_rr_ptr;
    w_cand  = '0;
    w_found = 1'b0;
    if (w_locked) begin
      w_sel = r_owner;
    end else begin
      for (int k = 0; k < int'(NUM_IN); k++) begin
        w_cand = IdxW'((int'(r_rr_ptr) + k) % int'(NUM_IN));
        if (!w_found && IN_valid[w_cand]) begin
          w_sel   = w_cand;
          w_found = 1'b1;
        end
      end
    end
  end

  assign w_gate     = w_locked || (IN_free >= MaxBurstFree);
  assign w_last     = IN_last[w_sel];
  assign w_overrun  = (r_beat_cnt + CntW'(1)) == MaxBurstCnt;
  assign w_next_ptr = (w_sel == LastIdx) ? '0 : w_sel + IdxW'(1);

  always_comb begin
    OUT_ready = '0;
    if (!rst && w_gate && IN_ready) begin
      OUT_ready[w_sel] = 1'b1;
    end
  end

  assign OUT_valid    = !rst && w_gate && IN_valid[w_sel];
  assign OUT_data     = IN_data[int'(w_sel) * WIDTH +: WIDTH];
  assign OUT_grantIdx = rst ? '0 : w_sel;
  assign OUT_locked   = !rst && w_locked;
  assign OUT_burstErr = !rst && r_burst_err;
  assign w_fire       = OUT_valid && IN_ready;

  always_comb begin
    w_state_d     = r_state;
    w_owner_d     = r_owner;
    w_rr_ptr_d    = r_rr_ptr;
    w_beat_cnt_d  = r_beat_cnt;
    w_burst_err_d = r_burst_err;
    if (w_fire) begin
      if (w_last || w_overrun) begin
        // Overrun forces a release so a runaway requester cannot starve the others.
        w_state_d    = StIdle;
        w_beat_cnt_d = '0;
        w_rr_ptr_d   = w_next_ptr;
        if (!w_last) begin
          w_burst_err_d = 1'b1;
        end
      end else begin
        w_state_d    = StBurst;
        w_owner_d    = w_sel;
        w_beat_cnt_d = r_beat_cnt + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_beat_cnt  <= '0;
      r_burst_err <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_owner     <= w_owner_d;
      r_rr_ptr    <= w_rr_ptr_d;
      r_beat_cnt  <= w_beat_cnt_d;
      r_burst_err <= w_burst_err_d;
    end
  end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Scoreboard bench for fifo_rr_arbiter: stimulus queues expected beats, a negedge monitor
// pops and compares every accepted beat; status outputs are checked directly.
module tb_fifo_rr_arbiter;

  localparam int unsigned NumIn    = 4;
  localparam int unsigned Width    = 32;
  localparam int unsigned FifoNum  = 4;
  localparam int unsigned MaxBurst = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NumIn-1:0]       in_valid;
  logic [NumIn*Width-1:0] in_data;
  logic [NumIn-1:0]       in_last;
  logic [NumIn-1:0]       out_ready;
  logic [2:0]             in_free;
  logic                   out_valid;
  logic [Width-1:0]       out_data;
  logic                   in_ready;
  logic [1:0]             out_grant;
  logic                   out_locked;
  logic                   out_burst_err;

  fifo_rr_arbiter #(
    .NUM_IN   (NumIn),
    .WIDTH    (Width),
    .FIFO_NUM (FifoNum),
    .MAX_BURST(MaxBurst)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .IN_valid    (in_valid),
    .IN_data     (in_data),
    .IN_last     (in_last),
    .OUT_ready   (out_ready),
    .IN_free     (in_free),
    .OUT_valid   (out_valid),
    .OUT_data    (out_data),
    .IN_ready    (in_ready),
    .OUT_grantIdx(out_grant),
    .OUT_locked  (out_locked),
    .OUT_burstErr(out_burst_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  idx;
    logic [31:0] data;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  int    n_checks = 0;
  int    n_errors = 0;

  function automatic logic [31:0] dat(input int lane, input int tag);
    return 32'hD000_0000 | (32'(tag) << 8) | 32'(lane);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] l, input int tag);
    in_valid = v;
    in_last  = l;
    for (int i = 0; i < int'(NumIn); i++) begin
      in_data[i*Width +: Width] = dat(i, tag);
    end
  endtask

  task automatic push(input int lane, input int tag);
    beat_t e;
    e.idx  = 2'(lane);
    e.data = dat(lane, tag);
    exp_q.push_back(e);
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_valid"}, 32'(out_valid), 32'd0);
    chk({name, "_ready"}, 32'(out_ready), 32'd0);
    chk({name, "_locked"}, 32'(out_locked), 32'd0);
    chk({name, "_err"}, 32'(out_burst_err), 32'd0);
    chk({name, "_grant"}, 32'(out_grant), 32'd0);
  endtask

  // Monitor: every accepted beat must match the head of the expected queue.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && in_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_beat: got lane %0d data %h required none", out_grant, out_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("beat_lane", 32'(out_grant), 32'(mon_e.idx));
        chk("beat_data", out_data, mon_e.data);
        chk("beat_ready", 32'(out_ready), 32'(4'b0001 << mon_e.idx));
      end
    end
  end

  initial begin
    rst      = 1'b1;
    in_free  = 3'd4;
    in_ready = 1'b1;
    drive(4'b0000, 4'b0000, 0);
    to_next();
    drive(4'b1111, 4'b1111, 0);
    to_neg();
    chk_quiet("rst");
    to_next();
    rst = 1'b0;

    // All requesters with single-beat bursts: strict rotation from 0.
    for (int k = 0; k < 5; k++) begin
      drive(4'b1111, 4'b1111, 10 + k);
      push(k % 4, 10 + k);
      to_neg();
      chk("rr_locked", 32'(out_locked), 32'd0);
      to_next();
    end

    // Requester 2 two-beat burst while 0 and 3 wait.
    drive(4'b1101, 4'b1001, 20);
    push(2, 20);
    to_neg();
    chk("b2_lock_pre", 32'(out_locked), 32'd0);
    to_next();
    drive(4'b1101, 4'b1101, 21);
    push(2, 21);
    to_neg();
    chk("b2_lock_mid", 32'(out_locked), 32'd1);
    chk("b2_grant_mid", 32'(out_grant), 32'd2);
    to_next();
    drive(4'b1001, 4'b1001, 22);
    push(3, 22);
    to_neg();
    chk("b2_lock_post", 32'(out_locked), 32'd0);
    to_next();
    drive(4'b1001, 4'b1001, 23);
    push(0, 23);
    to_next();
    drive(4'b0000, 4'b0000, 24);
    to_neg();
    chk("idle_grant", 32'(out_grant), 32'd1);
    chk("idle_valid", 32'(out_valid), 32'd0);
    to_next();

    // Start gate: free below MAX_BURST holds off, free == MAX_BURST lets it through.
    in_free = 3'd1;
    drive(4'b0010, 4'b0010, 30);
    to_neg();
    chk("gate_valid", 32'(out_valid), 32'd0);
    chk("gate_ready", 32'(out_ready), 32'd0);
    to_next();
    in_free = 3'd2;
    push(1, 30);
    to_neg();
    chk("gate_open", 32'(out_valid), 32'd1);
    to_next();

    // Locked owner 1 stalls on IN_ready, then free drops; lock keeps the port.
    in_free = 3'd4;
    drive(4'b0010, 4'b0000, 40);
    push(1, 40);
    to_next();
    drive(4'b1111, 4'b1111, 41);
    in_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      to_neg();
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_grant", 32'(out_grant), 32'd1);
      chk("stall_ready", 32'(out_ready), 32'd0);
      to_next();
    end
    in_free = 3'd0;
    to_neg();
    chk("nofree_valid", 32'(out_valid), 32'd1);
    chk("nofree_locked", 32'(out_locked), 32'd1);
    to_next();
    in_ready = 1'b1;
    push(1, 41);
    to_next();
    to_neg();
    chk("post_valid", 32'(out_valid), 32'd0);
    chk("post_grant", 32'(out_grant), 32'd2);
    chk("post_locked", 32'(out_locked), 32'd0);
    to_next();

    // Requester 0 overruns MAX_BURST: forced release and sticky error.
    in_free = 3'd4;
    drive(4'b0001, 4'b0000, 50);
    push(0, 50);
    to_next();
    drive(4'b0001, 4'b0000, 51);
    push(0, 51);
    to_neg();
    chk("ovr_lock", 32'(out_locked), 32'd1);
    chk("ovr_err_pre", 32'(out_burst_err), 32'd0);
    to_next();
    drive(4'b1111, 4'b1111, 52);
    push(1, 52);
    to_neg();
    chk("ovr_err", 32'(out_burst_err), 32'd1);
    chk("ovr_unlock", 32'(out_locked), 32'd0);
    to_next();
    drive(4'b1111, 4'b1111, 53);
    push(2, 53);
    to_neg();
    chk("ovr_err_sticky", 32'(out_burst_err), 32'd1);
    to_next();

    // Reset in the middle of owner 3's burst.
    drive(4'b1000, 4'b0000, 60);
    push(3, 60);
    to_next();
    drive(4'b1111, 4'b0000, 61);
    rst = 1'b1;
    to_neg();
    chk_quiet("midrst");
    to_next();
    rst = 1'b0;
    drive(4'b1111, 4'b1111, 62);
    push(0, 62);
    to_neg();
    chk("rst_locked", 32'(out_locked), 32'd0);
    chk("rst_err", 32'(out_burst_err), 32'd0);
    chk("rst_grant", 32'(out_grant), 32'd0);
    to_next();
    drive(4'b0000, 4'b0000, 63);
    to_next();
    to_next();

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
